tpu_job_sequencer: RTL and testbench

TPU_JOB_SEQUENCER -- requirements
Module: tpu_job_sequencer

---
 rtl/tpu_job_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_tpu_job_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_job_sequencer.sv
// tpu_job_sequencer: walks a byte-serial MAC engine through clear, accumulate,
// operand load, multiply wait and result readback for one job of N tiles.
module tpu_job_sequencer #(
  parameter int STROBE_GAP = 3,
  parameter int MUL_WAIT   = 8,
  parameter int RES_BYTES  = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_tiles,
  output logic       cmd_ready,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] eng_datos_in,
  output logic       eng_write,
  output logic       eng_clear,
  output logic       eng_accu,
  output logic       eng_read,
  input  logic [7:0] eng_datos_out,
  input  logic       eng_ena_out,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       res_last,
  input  logic       res_ready,
  output logic       busy,
  output logic       err
);

  localparam int GAP_CYC = (STROBE_GAP > 0) ? STROBE_GAP : 1;
  localparam int MW_CYC  = (MUL_WAIT > GAP_CYC) ? MUL_WAIT : GAP_CYC;
  localparam int TO_CYC  = (TIMEOUT > 0) ? TIMEOUT : 1;
  localparam int TMAX_A  = (TO_CYC > MW_CYC) ? TO_CYC : MW_CYC;
  localparam int TW      = $clog2(TMAX_A + 1);
  localparam int RW      = $clog2(RES_BYTES + 1);

  localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] MW_LD   = TW'(MW_CYC - 1);
  localparam logic [TW-1:0] TO_LD   = TW'(TO_CYC - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(RES_BYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_ARM,
    S_LOAD,
    S_GAP,
    S_MUL_WAIT,
    S_READ,
    S_WAIT_OUT,
    S_PUSH
  } state_t;

  state_t          state;
  state_t          state_d;
  state_t          gap_ret;
  state_t          gap_ret_d;
  logic [3:0]      tiles_left;
  logic [1:0]      byte_cnt;
  logic [RW-1:0]   rd_cnt;
  logic [TW-1:0]   timer;
  logic            ena_prev;
  logic            ena_rise;
  logic            accept;
  logic            timer_zero;
  logic            rd_last;

  assign ena_rise   = eng_ena_out & ~ena_prev;
  assign accept     = (state == S_LOAD) & in_valid;
  assign timer_zero = (timer == '0);
  assign rd_last    = (rd_cnt == RD_LAST);

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign in_ready  = (state == S_LOAD);
  assign res_valid = (state == S_PUSH);
  assign res_last  = (state == S_PUSH) & rd_last;

  always_comb begin
    state_d   = state;
    gap_ret_d = gap_ret;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d   = S_GAP;
        gap_ret_d = S_ARM;
      end
      S_ARM: begin
        state_d   = S_GAP;
        gap_ret_d = S_LOAD;
      end
      S_LOAD: begin
        if (in_valid) begin
          if (byte_cnt == 2'd3) begin
            state_d = S_MUL_WAIT;
          end else begin
            state_d   = S_GAP;
            gap_ret_d = S_LOAD;
          end
        end
      end
      S_GAP: begin
        if (timer_zero) state_d = gap_ret;
      end
      S_MUL_WAIT: begin
        if (timer_zero) begin
          state_d = (tiles_left != 4'd0) ? S_LOAD : S_READ;
        end
      end
      S_READ: begin
        state_d = S_WAIT_OUT;
      end
      S_WAIT_OUT: begin
        if (ena_rise || timer_zero) state_d = S_PUSH;
      end
      S_PUSH: begin
        if (res_ready) begin
          if (rd_last) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_GAP;
            gap_ret_d = S_READ;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      gap_ret <= S_IDLE;
    end else begin
      state   <= state_d;
      gap_ret <= gap_ret_d;
    end
  end

  // Strobes are registered one cycle after their state so they never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_clear    <= 1'b0;
      eng_accu     <= 1'b0;
      eng_write    <= 1'b0;
      eng_read     <= 1'b0;
      eng_datos_in <= 8'h00;
      ena_prev     <= 1'b0;
    end else begin
      eng_clear <= (state == S_CLEAR);
      eng_accu  <= (state == S_ARM);
      eng_write <= accept;
      eng_read  <= (state == S_READ);
      ena_prev  <= eng_ena_out;
      if (accept) eng_datos_in <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (state_d != state) begin
      unique case (state_d)
        S_GAP:      timer <= GAP_LD;
        S_MUL_WAIT: timer <= MW_LD;
        S_WAIT_OUT: timer <= TO_LD;
        default:    timer <= '0;
      endcase
    end else if (!timer_zero) begin
      timer <= timer - TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tiles_left <= 4'd0;
      byte_cnt   <= 2'd0;
      rd_cnt     <= '0;
      res_data   <= 8'h00;
      err        <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            tiles_left <= (cmd_tiles == 4'd0) ? 4'd1 : cmd_tiles;
            byte_cnt   <= 2'd0;
            rd_cnt     <= '0;
            err        <= 1'b0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (byte_cnt == 2'd3) begin
              byte_cnt   <= 2'd0;
              tiles_left <= tiles_left - 4'd1;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        S_MUL_WAIT: begin
          if (timer_zero && tiles_left == 4'd0) rd_cnt <= '0;
        end
        S_WAIT_OUT: begin
          if (ena_rise) begin
            res_data <= eng_datos_out;
          end else if (timer_zero) begin
            res_data <= 8'h00;
            err      <= 1'b1;
          end
        end
        S_PUSH: begin
          if (res_ready && !rd_last) rd_cnt <= rd_cnt + RW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// tb_tpu_job_sequencer: job table plus reset-abandon sequence, with an engine
// model, operand feeder, result scoreboard and strobe-spacing monitor.
module tb_tpu_job_sequencer;

  localparam int STROBE_GAP = 3;
  localparam int MUL_WAIT   = 8;
  localparam int RES_BYTES  = 2;
  localparam int TIMEOUT    = 64;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic [3:0] cmd_tiles;
  logic       cmd_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] eng_datos_in;
  logic       eng_write;
  logic       eng_clear;
  logic       eng_accu;
  logic       eng_read;
  logic [7:0] eng_datos_out;
  logic       eng_ena_out;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_last;
  logic       res_ready;
  logic       busy;
  logic       err;

  tpu_job_sequencer #(
    .STROBE_GAP(STROBE_GAP),
    .MUL_WAIT(MUL_WAIT),
    .RES_BYTES(RES_BYTES),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_tiles(cmd_tiles),
    .cmd_ready(cmd_ready),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .eng_datos_in(eng_datos_in),
    .eng_write(eng_write),
    .eng_clear(eng_clear),
    .eng_accu(eng_accu),
    .eng_read(eng_read),
    .eng_datos_out(eng_datos_out),
    .eng_ena_out(eng_ena_out),
    .res_valid(res_valid),
    .res_data(res_data),
    .res_last(res_last),
    .res_ready(res_ready),
    .busy(busy),
    .err(err)
  );

  typedef struct {
    logic [3:0] tiles;
    logic [7:0] base;
    logic [7:0] r0;
    logic [7:0] r1;
    logic       dead;
    int         hold;
    int         exp_wr;
    logic [7:0] e0;
    logic [7:0] e1;
    logic       exp_err;
  } job_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       err;
  } res_t;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;

  logic [7:0] byte_q[$];
  logic [7:0] eng_q[$];
  res_t       exp_q[$];
  int         seq_q[$];
  logic [7:0] wr_data_q[$];
  int         wr_time_q[$];

  logic eng_dead = 1'b0;
  int   hold_cfg = 0;
  int   gap_viol = 0;
  int   onehot_viol = 0;
  int   stab_viol = 0;
  int   rd_in_push = 0;

  job_t jobs[5];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Engine: answers each read with one eng_ena_out pulse a few cycles later.
  initial begin
    int eng_cnt;
    eng_cnt = 0;
    eng_ena_out = 1'b0;
    eng_datos_out = 8'h00;
    forever begin
      @(posedge clk);
      if (rst) begin
        eng_ena_out <= 1'b0;
        eng_cnt = 0;
      end else begin
        eng_ena_out <= 1'b0;
        if (eng_cnt != 0) begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            eng_ena_out <= 1'b1;
            eng_datos_out <= (eng_q.size() != 0) ? eng_q.pop_front() : 8'hEE;
          end
        end else if (eng_read && !eng_dead) begin
          eng_cnt = 5;
        end
      end
    end
  end

  initial begin
    logic take;
    take = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    forever begin
      @(negedge clk);
      if (take && byte_q.size() != 0) void'(byte_q.pop_front());
      in_valid = (byte_q.size() != 0);
      in_data  = in_valid ? byte_q[0] : 8'h00;
      take     = in_valid && in_ready && !rst;
    end
  end

  initial begin
    int low_run;
    int nstb;
    low_run = 1000;
    forever begin
      @(negedge clk);
      if (rst) begin
        low_run = 1000;
      end else begin
        nstb = int'(eng_clear) + int'(eng_accu) + int'(eng_write) + int'(eng_read);
        if (nstb > 1) onehot_viol++;
        if (eng_read && res_valid) rd_in_push++;
        if (nstb != 0) begin
          if (low_run < STROBE_GAP) gap_viol++;
          low_run = 0;
          if (eng_clear) seq_q.push_back(0);
          if (eng_accu) seq_q.push_back(1);
          if (eng_write) begin
            seq_q.push_back(2);
            wr_data_q.push_back(eng_datos_in);
            wr_time_q.push_back(cyc);
          end
          if (eng_read) seq_q.push_back(3);
        end else if (low_run < 1000) begin
          low_run++;
        end
      end
    end
  end

  initial begin
    int hold;
    logic [7:0] held;
    res_t e;
    hold = 0;
    held = 8'h00;
    res_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !res_valid) begin
        res_ready = 1'b0;
        hold = 0;
      end else if (hold < hold_cfg) begin
        if (hold == 0) held = res_data;
        else if (res_data !== held) stab_viol++;
        res_ready = 1'b0;
        hold++;
      end else begin
        if (hold_cfg > 0 && res_data !== held) stab_viol++;
        res_ready = 1'b1;
        hold = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_result", {15'd0, err, res_last, res_data}, 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("result", {22'd0, err, res_last, res_data},
                {22'd0, e.err, e.last, e.data});
        end
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    check(name,
          {cmd_ready, in_ready, busy, err, res_valid, res_last,
           eng_write, eng_clear, eng_accu, eng_read, eng_datos_in, res_data},
          {1'b1, 25'd0});
  endtask

  task automatic run_job(input job_t j);
    int limit;
    int bad;
    int ntiles;
    int exp_len;
    int d;
    res_t r;
    ntiles = j.exp_wr / 4;
    seq_q.delete();
    wr_data_q.delete();
    wr_time_q.delete();
    for (int i = 0; i < j.exp_wr; i++) byte_q.push_back(j.base + 8'(i));
    eng_dead = j.dead;
    hold_cfg = j.hold;
    if (!j.dead) begin
      eng_q.push_back(j.r0);
      eng_q.push_back(j.r1);
    end
    r.data = j.e0; r.last = 1'b0; r.err = j.exp_err;
    exp_q.push_back(r);
    r.data = j.e1; r.last = 1'b1; r.err = j.exp_err;
    exp_q.push_back(r);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_tiles = j.tiles;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_cmd", {31'd0, busy}, 32'd1);
    check("err_after_cmd", {31'd0, err}, 32'd0);
    limit = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && limit < 3000) begin
      @(negedge clk);
      limit++;
    end
    check("job_done", {31'd0, limit < 3000}, 32'd1);
    exp_len = 2 + j.exp_wr + RES_BYTES;
    check("strobe_count", seq_q.size(), exp_len);
    bad = 0;
    for (int i = 0; i < seq_q.size() && i < exp_len; i++) begin
      if (i == 0) bad += (seq_q[i] != 0) ? 1 : 0;
      else if (i == 1) bad += (seq_q[i] != 1) ? 1 : 0;
      else if (i < 2 + j.exp_wr) bad += (seq_q[i] != 2) ? 1 : 0;
      else bad += (seq_q[i] != 3) ? 1 : 0;
    end
    check("strobe_order", bad, 0);
    check("write_count", wr_data_q.size(), j.exp_wr);
    for (int i = 0; i < wr_data_q.size() && i < j.exp_wr; i++)
      check("write_data", wr_data_q[i], j.base + 8'(i));
    check("bytes_left", byte_q.size(), 0);
    // Operands are always ready, so the tile-to-tile write spacing is the
    // multiply wait plus the load cycle.
    if (wr_time_q.size() == j.exp_wr) begin
      for (int t = 1; t < ntiles; t++) begin
        d = wr_time_q[4*t] - wr_time_q[4*t-1];
        check("mul_wait_gap", {31'd0, d >= MUL_WAIT && d <= MUL_WAIT + 2}, 32'd1);
      end
    end
  endtask

  initial begin
    int limit;
    jobs[0] = '{4'd1, 8'h01, 8'hAA, 8'hBB, 1'b0, 0,  4,  8'hAA, 8'hBB, 1'b0};
    jobs[1] = '{4'd3, 8'h10, 8'h11, 8'h22, 1'b0, 0,  12, 8'h11, 8'h22, 1'b0};
    jobs[2] = '{4'd0, 8'h40, 8'h5A, 8'hA5, 1'b0, 0,  4,  8'h5A, 8'hA5, 1'b0};
    jobs[3] = '{4'd1, 8'h60, 8'h77, 8'h88, 1'b1, 0,  4,  8'h00, 8'h00, 1'b1};
    jobs[4] = '{4'd2, 8'h80, 8'h01, 8'hFE, 1'b0, 20, 8,  8'h01, 8'hFE, 1'b0};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_tiles = 4'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      run_job(jobs[k]);
      if (jobs[k].exp_err) check("err_sticky", {31'd0, err}, 32'd1);
    end

    // Abandon a job with a reset while the third operand byte is offered.
    byte_q.delete();
    for (int i = 0; i < 4; i++) byte_q.push_back(8'h20 + 8'(i));
    eng_dead = 1'b0;
    hold_cfg = 0;
    seq_q.delete();
    wr_data_q.delete();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_tiles = 4'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    limit = 0;
    while (!(wr_data_q.size() == 2 && in_ready) && limit < 200) begin
      @(negedge clk);
      limit++;
    end
    check("reach_third_byte", {31'd0, limit < 200}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_job");
    @(negedge clk);
    check_reset_outputs("reset_held");
    rst = 1'b0;
    byte_q.delete();
    eng_q.delete();
    exp_q.delete();
    seq_q.delete();
    repeat (6) @(negedge clk);
    check("no_strobe_after_rst", seq_q.size(), 0);
    check_reset_outputs("idle_after_rst");
    run_job('{4'd0, 8'h30, 8'hC3, 8'h3C, 1'b0, 0, 4, 8'hC3, 8'h3C, 1'b0});

    check("strobe_spacing", gap_viol, 0);
    check("strobe_onehot", onehot_viol, 0);
    check("push_stable", stab_viol, 0);
    check("read_during_push", rd_in_push, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
